display_unit_seq: RTL
=====================

Name: display_unit_seq

Overview:
- Parametrised sequential successor to the calculator's combinational output path.
- Converts a signed DATA_W-bit result to sign-magnitude BCD with an iterative double-dabble engine, one shift per cycle.
- Selects between that result and the input unit's pre-formatted BCD, then drives NUM_DISP active-low 7-segment digits.
- Adds leading-zero blanking, a floating minus sign, paged viewing of long numbers and a "more digits" indicator.

Parameters:
- DATA_W, 32: signed input width.
- BCD_DIGITS, 10: BCD magnitude digits. Must hold 2^(DATA_W-1).
- NUM_DISP, 6: physical 7-segment displays.
- PAGE_W, 2: width of the page select.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: capture data_in and begin conversion; honoured only in IDLE.
- data_in, input, DATA_W: two's-complement value to convert.
- toggle, input, 1: 0 = show converted result, 1 = show bcd_iu.
- bcd_iu, input, 4*(BCD_DIGITS+1): top nibble nonzero = negative; lower nibbles are digits, LS digit at [3:0].
- page, input, PAGE_W: display window select.
- busy, output, 1: conversion in progress.
- done, output, 1: one-cycle pulse when the result register updates.
- more, output, 1: a lit position exists above the current window.
- hex, output, 7*NUM_DISP: segments gfedcba, active-low; hex[7*i +: 7] = display i, i=0 rightmost.

Behaviour:
- Reset is asynchronous. Reset values:
  - state = IDLE, busy = 0, done = 0, more = 0
  - result BCD = 0, result sign = 0
  - hex = all 7'h7F (blank)
- FSM states: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
  - IDLE: start=1 captures data_in and moves to LOAD. start=0 stays in IDLE.
  - LOAD: sign = data_in[DATA_W-1]; magnitude = |data_in| in DATA_W unsigned bits (-2^(DATA_W-1) is representable); BCD scratch = 0; shift counter = 0.
  - SHIFT: each cycle, add 3 to every scratch digit >= 5, then shift {scratch, magnitude} left by 1. After DATA_W shifts go to DONE.
  - DONE: copy scratch and sign into the result register; done=1 for this cycle; return to IDLE.
- busy = 1 in LOAD, SHIFT and DONE.
- Latency: start sampled at edge N -> done high during cycle N+DATA_W+2 -> new result visible on hex one cycle later.
- start while busy is ignored; no queueing.
- The result register holds the previous value throughout a conversion, so the display does not flicker.
- Reset mid-conversion aborts the conversion; the result register is cleared and nothing is committed.
- Display source: toggle=0 uses the result register; toggle=1 uses bcd_iu. The source switch takes effect on the next edge, independent of FSM state.
- Position space: positions 0..BCD_DIGITS.
  - msd = highest nonzero digit index, or 0 if all digits are zero.
  - Position p <= msd shows its digit.
  - Position msd+1 shows minus (7'b0111111) if negative and the magnitude is nonzero; -0 displays as 0.
  - All other positions are blank (7'h7F).
  - Digit nibbles > 9 display blank.
- Window: display i shows position page*NUM_DISP + i. Positions > BCD_DIGITS are blank.
- more = 1 iff any digit or sign position above page*NUM_DISP + NUM_DISP - 1 is lit.
- hex and more are registered: one cycle after any change in source, page or result.

Test Plan:
- Reset asserted mid-SHIFT (cycle 10 after start of 99) -> busy=0 and hex all 7'h7F immediately; next cycle HEX0=7'h40 ("0"), rest blank; done never pulses.
- start with data_in=12345, toggle=0, page=0 -> busy for 34 cycles; done pulses at cycle N+34; next cycle HEX4..HEX0 = 1,2,3,4,5 (7'h79,24,30,19,12); HEX5 blank; more=0.
- data_in=-2147483648, page=0 -> HEX5..0 = 483648, more=1. page=1 -> HEX4='-' (7'h3F), HEX3..0 = 2,1,4,7, HEX5 blank, more=0.
- data_in=-7, then a second start pulse 5 cycles later with 500 -> only one conversion runs; HEX1='-', HEX0=7 (7'h78); done pulses exactly once.
- toggle=1, bcd_iu sign nibble=1, digits=0000000042 -> HEX2='-', HEX1=4, HEX0=2, others blank. Clear the sign nibble -> minus disappears within one cycle.
- data_in=0 -> HEX0="0", HEX5..1 blank, more=0. page=1 -> all blank, more=0.

Source files
------------

// File: rtl/display_unit_seq.sv
// Signed binary to sign-magnitude BCD converter (iterative double dabble) feeding a
// paged, leading-zero-blanked 7-segment display with a floating minus sign.
module display_unit_seq #(
  parameter int DATA_W     = 32,
  parameter int BCD_DIGITS = 10,
  parameter int NUM_DISP   = 6,
  parameter int PAGE_W     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      toggle,
  input  logic [4*(BCD_DIGITS+1)-1:0] bcd_iu,
  input  logic [PAGE_W-1:0]         page,
  output logic                      busy,
  output logic                      done,
  output logic                      more,
  output logic [7*NUM_DISP-1:0]     hex
);

  localparam int SCR_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(DATA_W - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  data_reg;
  logic [DATA_W-1:0]  mag;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   adj;
  logic               sign_reg;
  logic [SCR_W-1:0]   res_bcd;
  logic               res_sign;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h40;
      4'd1:    seg_of = 7'h79;
      4'd2:    seg_of = 7'h24;
      4'd3:    seg_of = 7'h30;
      4'd4:    seg_of = 7'h19;
      4'd5:    seg_of = 7'h12;
      4'd6:    seg_of = 7'h02;
      4'd7:    seg_of = 7'h78;
      4'd8:    seg_of = 7'h00;
      4'd9:    seg_of = 7'h10;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction applied before each shift.
  always_comb begin
    adj = scratch;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      data_reg <= '0;
      mag      <= '0;
      scratch  <= '0;
      sign_reg <= 1'b0;
      res_bcd  <= '0;
      res_sign <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            data_reg <= data_in;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          sign_reg <= data_reg[DATA_W-1];
          // -2^(DATA_W-1) negates to itself, which is the correct unsigned magnitude.
          mag      <= data_reg[DATA_W-1] ? (~data_reg + DATA_W'(1)) : data_reg;
          scratch  <= '0;
          cnt      <= '0;
          state    <= SHIFT;
        end
        SHIFT: begin
          {scratch, mag} <= {adj[SCR_W-2:0], mag, 1'b0};
          cnt            <= cnt + CNT_W'(1);
          if (cnt == LAST_SHIFT) state <= DONE;
        end
        DONE: begin
          res_bcd  <= scratch;
          res_sign <= sign_reg;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  logic [SCR_W-1:0]      src_digits;
  logic                  src_neg;
  logic                  src_nz;
  int                    msd;
  int                    win_base;
  logic [6:0]            pos_seg [0:BCD_DIGITS];
  logic [7*NUM_DISP-1:0] next_hex;
  logic                  next_more;

  always_comb begin
    src_digits = toggle ? bcd_iu[SCR_W-1:0] : res_bcd;
    src_neg    = toggle ? (bcd_iu[SCR_W +: 4] != 4'd0) : res_sign;
    msd        = 0;
    src_nz     = 1'b0;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (src_digits[4*d +: 4] != 4'd0) begin
        msd    = d;
        src_nz = 1'b1;
      end
    end
    // Position space holds every digit plus one slot for the minus above the top digit.
    for (int p = 0; p <= BCD_DIGITS; p++) begin
      pos_seg[p] = SEG_BLANK;
      if (p < BCD_DIGITS && p <= msd)
        pos_seg[p] = seg_of(src_digits[4*p +: 4]);
      else if (p == msd + 1 && src_neg && src_nz)
        pos_seg[p] = SEG_MINUS;
    end
  end

  always_comb begin
    win_base  = int'(page) * NUM_DISP;
    next_hex  = {NUM_DISP{SEG_BLANK}};
    next_more = 1'b0;
    for (int i = 0; i < NUM_DISP; i++) begin
      for (int p = 0; p <= BCD_DIGITS; p++) begin
        if (p == win_base + i) next_hex[7*i +: 7] = pos_seg[p];
      end
    end
    for (int p = 0; p <= BCD_DIGITS; p++) begin
      if (p > win_base + NUM_DISP - 1 && pos_seg[p] != SEG_BLANK) next_more = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex  <= {NUM_DISP{SEG_BLANK}};
      more <= 1'b0;
    end else begin
      hex  <= next_hex;
      more <= next_more;
    end
  end

endmodule
